// File: rtl/gates_tt_pkg.sv
// Shared types and golden data for the two-input gate truth-table checker.
// Response bit order is {xnor, xor, nor, nand, or, and, not_b, not_a}.
package gates_tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned RESP_W = 8;

    localparam int unsigned BIT_NOT_A = 0;
    localparam int unsigned BIT_NOT_B = 1;
    localparam int unsigned BIT_AND   = 2;
    localparam int unsigned BIT_OR    = 3;
    localparam int unsigned BIT_NAND  = 4;
    localparam int unsigned BIT_NOR   = 5;
    localparam int unsigned BIT_XOR   = 6;
    localparam int unsigned BIT_XNOR  = 7;

    localparam logic [1:0] LAST_VEC = 2'd3;

    // Golden response for input vector {a,b}.
    function automatic logic [RESP_W-1:0] expected_resp(input logic [1:0] vec);
        logic [RESP_W-1:0] r;
        r = '0;
        unique case (vec)
            2'd0: r = 8'hB3;
            2'd1: r = 8'h59;
            2'd2: r = 8'h5A;
            2'd3: r = 8'h8C;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gates_tt_checker.sv
// Stimulus-and-check engine: walks all four {a,b} vectors, waits SETTLE_CYCLES,
// compares the gate block's responses to the golden table and accumulates results.
module gates_tt_checker
    import gates_tt_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              a,
    output logic              b,
    input  logic [RESP_W-1:0] resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [RESP_W-1:0] fail_mask,
    output logic [2:0]        err_count,
    output logic [1:0]        first_fail_vec
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $fatal(1, "gates_tt_checker: SETTLE_CYCLES must be in 1..15");
    end

    // Counter is loaded with SETTLE_CYCLES-1 so APPLY lasts exactly SETTLE_CYCLES cycles.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        vec;
    logic [3:0]        settle_cnt;
    logic [RESP_W-1:0] mm;
    logic              run_req;

    assign run_req = start && (state == ST_IDLE || state == ST_DONE);
    assign mm      = resp ^ expected_resp(vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_APPLY;
            end
            ST_APPLY: begin
                if (abort)                 state_nxt = ST_IDLE;
                else if (settle_cnt == '0) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (abort)                 state_nxt = ST_IDLE;
                else if (vec == LAST_VEC)  state_nxt = ST_DONE;
                else                       state_nxt = ST_APPLY;
            end
            ST_DONE: begin
                if (start) state_nxt = ST_APPLY;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Abort in CHECK suppresses the update, so an aborted run keeps earlier results only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec            <= '0;
            settle_cnt     <= '0;
            fail_mask      <= '0;
            err_count      <= '0;
            first_fail_vec <= '0;
        end else if (run_req) begin
            vec            <= '0;
            settle_cnt     <= SETTLE_LOAD;
            fail_mask      <= '0;
            err_count      <= '0;
            first_fail_vec <= '0;
        end else if (state == ST_APPLY && !abort && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 4'd1;
        end else if (state == ST_CHECK && !abort) begin
            fail_mask <= fail_mask | mm;
            if (mm != '0) begin
                err_count <= err_count + 3'd1;
                if (err_count == '0) first_fail_vec <= vec;
            end
            if (vec != LAST_VEC) begin
                vec        <= vec + 2'd1;
                settle_cnt <= SETTLE_LOAD;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        a    = 1'b0;
        b    = 1'b0;
        unique case (state)
            ST_IDLE: ;
            ST_APPLY, ST_CHECK: begin
                busy = 1'b1;
                a    = vec[1];
                b    = vec[0];
            end
            ST_DONE: begin
                done = 1'b1;
                pass = (fail_mask == '0);
                a    = vec[1];
                b    = vec[0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gates_tt_checker.sv
// Directed bench for gates_tt_checker: a behavioural gate model with injectable
// faults drives the default instance; a second instance uses SETTLE_CYCLES=1.
module tb_gates_tt_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       a, b;
    logic [7:0] resp;
    logic       busy, done, pass;
    logic [7:0] fail_mask;
    logic [2:0] err_count;
    logic [1:0] first_fail_vec;

    logic       start2;
    logic       abort2;
    logic       a2, b2;
    logic [7:0] resp2;
    logic       busy2, done2, pass2;
    logic [7:0] fail_mask2;
    logic [2:0] err_count2;
    logic [1:0] first_fail_vec2;

    int checks;
    int errors;
    int mode;   // 0: correct gates, 1: xor stuck at 0, 2: all outputs 1

    gates_tt_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a(a), .b(b), .resp(resp),
        .busy(busy), .done(done), .pass(pass),
        .fail_mask(fail_mask), .err_count(err_count), .first_fail_vec(first_fail_vec)
    );

    gates_tt_checker #(.SETTLE_CYCLES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .a(a2), .b(b2), .resp(resp2),
        .busy(busy2), .done(done2), .pass(pass2),
        .fail_mask(fail_mask2), .err_count(err_count2), .first_fail_vec(first_fail_vec2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Gate block model: {xnor, xor, nor, nand, or, and, not_b, not_a}.
    always_comb begin
        resp = {~(a ^ b), (a ^ b), ~(a | b), ~(a & b), (a | b), (a & b), ~b, ~a};
        if (mode == 1) resp[6] = 1'b0;
        if (mode == 2) resp = 8'hFF;
    end

    assign resp2 = 8'hFF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start sampled at the end of cycle 0; returns in cycle 1.
    task automatic begin_run(input int which);
        if (which == 2) start2 = 1'b1; else start = 1'b1;
        tick();
        start2 = 1'b0;
        start  = 1'b0;
    endtask

    task automatic run_to_done(input int from_cyc, output int cyc);
        cyc = from_cyc;
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    int cyc;

    initial begin
        checks = 0;
        errors = 0;
        mode   = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        start2 = 1'b0;
        abort2 = 1'b0;

        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_ab", {a, b}, 2'b00);
        check("rst_mask", fail_mask, 8'h00);
        check("rst_err", err_count, 3'd0);
        check("rst_ffv", first_fail_vec, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Correct gates, default settle: vectors at cycles 1,4,7,10, done at 13.
        mode = 0;
        begin_run(1);
        check("t1_busy_c1", busy, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            if (c == 1)  check("t1_ab_c1", {a, b}, 2'b00);
            if (c == 4)  check("t1_ab_c4", {a, b}, 2'b01);
            if (c == 7)  check("t1_ab_c7", {a, b}, 2'b10);
            if (c == 10) check("t1_ab_c10", {a, b}, 2'b11);
            if (c == 12) check("t1_done_c12", done, 1'b0);
            tick();
        end
        check("t1_done_c13", done, 1'b1);
        check("t1_pass", pass, 1'b1);
        check("t1_mask", fail_mask, 8'h00);
        check("t1_err", err_count, 3'd0);
        check("t1_ab_done", {a, b}, 2'b11);

        // XOR stuck at 0, with a start pulse in cycle 4 that must be ignored.
        mode = 1;
        begin_run(1);
        tick(); tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_busy_c5", busy, 1'b1);
        run_to_done(5, cyc);
        check("t5_done_cycle", 8'(cyc), 8'd13);
        check("t2_mask", fail_mask, 8'h40);
        check("t2_err", err_count, 3'd2);
        check("t2_ffv", first_fail_vec, 2'd1);
        check("t2_pass", pass, 1'b0);

        // Abort in DONE is ignored.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_in_done", done, 1'b1);
        check("abort_in_done_err", err_count, 3'd2);

        // Start in DONE clears results and re-runs.
        mode = 0;
        begin_run(1);
        check("t5_rerun_mask", fail_mask, 8'h00);
        check("t5_rerun_err", err_count, 3'd0);
        check("t5_rerun_busy", busy, 1'b1);
        run_to_done(1, cyc);
        check("t5_rerun_cycle", 8'(cyc), 8'd13);
        check("t5_rerun_pass", pass, 1'b1);

        // Abort in cycle 5 with all-ones responses: only vector 0 was checked.
        mode = 2;
        begin_run(1);
        tick(); tick(); tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t3_busy", busy, 1'b0);
        check("t3_done", done, 1'b0);
        check("t3_ab", {a, b}, 2'b00);
        check("t3_mask", fail_mask, 8'h4C);
        check("t3_err", err_count, 3'd1);
        tick(); tick(); tick();
        check("t3_mask_frozen", fail_mask, 8'h4C);
        check("t3_err_frozen", err_count, 3'd1);
        check("t3_pass", pass, 1'b0);

        // Abort during the final CHECK (cycle 12) wins over the last update.
        begin_run(1);
        for (int i = 0; i < 11; i++) tick();
        check("t3b_busy_c12", busy, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t3b_done", done, 1'b0);
        check("t3b_busy", busy, 1'b0);
        check("t3b_err", err_count, 3'd3);
        check("t3b_mask", fail_mask, 8'hEF);
        check("t3b_ffv", first_fail_vec, 2'd0);

        // Reset asserted in cycle 7 of a failing run takes effect immediately.
        begin_run(1);
        for (int i = 0; i < 6; i++) tick();
        check("t4_pre_mask", fail_mask, 8'hEE);
        rst_n = 1'b0;
        #1;
        check("t4_busy", busy, 1'b0);
        check("t4_ab", {a, b}, 2'b00);
        check("t4_mask", fail_mask, 8'h00);
        check("t4_err", err_count, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        mode = 0;
        begin_run(1);
        check("t4_run_ab", {a, b}, 2'b00);
        run_to_done(1, cyc);
        check("t4_run_cycle", 8'(cyc), 8'd13);
        check("t4_run_pass", pass, 1'b1);

        // SETTLE_CYCLES=1 instance with responses forced to all ones.
        begin_run(2);
        cyc = 1;
        while (done2 !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("t6_done_cycle", 8'(cyc), 8'd9);
        check("t6_err", err_count2, 3'd4);
        check("t6_ffv", first_fail_vec2, 2'd0);
        // Union of FF^B3, FF^59, FF^5A, FF^8C: xnor mismatches on vectors 1 and 2.
        check("t6_mask", fail_mask2, 8'hFF);
        check("t6_pass", pass2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
